uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the existing UART transmitter in the PC link.
- Samples the asynchronous serial line `rx` and recovers 8-bit bytes, LSB first, at the same bit period as the transmitter (105 clk cycles per bit).
- Presents each byte in a holding register with a level-valid / acknowledge handshake toward the CPU-side logic.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 105, clk cycles per serial bit; must be >= 4.
- HALF_BIT, (CLKS_PER_BIT-1)/2 = 52, cycles from start-edge detection to the start-bit sample.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- rx  input  1  asynchronous serial input, idle high
- rd_ack  input  1  one-cycle pulse; consumer has taken rx_data
- rx_data  output  8  last correctly received byte
- data_ready  output  1  rx_data holds an unread byte (level)
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  sticky: a byte was written while data_ready=1; cleared only by rst

Behaviour:
- Reset:
  - State=IDLE. rx_data=0x00, data_ready=0, frame_err=0, overrun=0.
  - Bit counter=0, cycle counter=0.
  - Both synchronizer flops =1.
- Synchronizer: two-flop chain on rx, giving rx_s. All decisions use rx_s; line-to-rx_s latency is 2 cycles.
- IDLE:
  - Start detection is a falling edge only: rx_s=0 while the previous rx_s=1.
  - In that cycle (D): go to START, cycle counter=0.
  - A line held low, e.g. after a break or after reset mid-frame, never starts a frame.
- START:
  - Counter increments each cycle. The sample is taken when counter==HALF_BIT, i.e. at cycle D+HALF_BIT.
  - rx_s=0: go to DATA, counter=0, bit index=0.
  - rx_s=1: false start, go to IDLE; no outputs change.
- DATA:
  - Counter increments. When counter==CLKS_PER_BIT-1: sample rx_s into shift register MSB, shift right, counter=0, bit index+1.
  - After the 8th sample, go to STOP.
  - Data bit k is sampled at D+HALF_BIT+(k+1)*CLKS_PER_BIT.
- STOP:
  - Sample at counter==CLKS_PER_BIT-1, i.e. at D+HALF_BIT+9*CLKS_PER_BIT (D+997 at default).
  - rx_s=1:
    - rx_data<=shift register, data_ready<=1 on the next cycle.
    - If data_ready was already 1 and rd_ack is not asserted this cycle, overrun<=1 and the old byte is overwritten.
  - rx_s=0: frame_err pulses 1 for one cycle; rx_data and data_ready are unchanged.
  - Either case: go to IDLE.
  - End-to-end at default: line falling edge at cycle T gives data_ready=1 at cycle T+1000.
- Handshake:
  - rd_ack while data_ready=1: data_ready<=0 next cycle.
  - rd_ack while data_ready=0: ignored.
  - rd_ack in the same cycle as a byte store: the store wins, data_ready stays 1, no overrun.
- Back-to-back frames: the stop sample is at mid stop bit, so IDLE is re-entered about half a bit before the next start edge. A start bit that immediately follows a stop bit is caught.
- rst asserted mid-frame: aborts at once to the reset state. The partial byte is discarded and no error is flagged.
- rx glitches while in DATA or STOP are not filtered; only the mid-bit sample counts.

Test Plan:
- Single byte:
  - Stimulus: drive frame 0xA5 at 105 cycles/bit (start, 1,0,1,0,0,1,0,1, stop).
  - Required: data_ready rises exactly 1000 cycles after rx falls; rx_data=0xA5; frame_err and overrun stay 0.
  - Then rd_ack pulse → data_ready=0 next cycle.
- Back-to-back:
  - Stimulus: 0x00, 0xFF, 0x55 with no idle gap; rd_ack pulsed after each.
  - Required: three data_ready assertions with rx_data 0x00, 0xFF, 0x55 in order; no errors.
- False start:
  - Stimulus: rx low for 20 cycles, then high for 2000 cycles.
  - Required: state returns to IDLE; data_ready, frame_err and rx_data unchanged.
- Framing error:
  - Stimulus: frame 0x3C with stop bit held low, then line high.
  - Required: a single 1-cycle frame_err pulse at stop-sample +1; data_ready stays 0.
  - A following valid 0x81 frame is received correctly.
- Overrun:
  - Stimulus: receive 0x11 with no rd_ack, then receive 0x22.
  - Required: rx_data=0x22, data_ready=1, overrun=1 and stays 1 until rst.
  - Repeat with rd_ack asserted in the store cycle of 0x22 → overrun stays 0.
- Reset mid-frame:
  - Stimulus: assert rst for 1 cycle during bit 4 of a frame, with rx low at that moment.
  - Required: all outputs go to reset values; no byte and no frame_err from the aborted frame.
  - The next clean 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver: 2-flop synchronised line, falling-edge start detect, mid-bit sampling.
// Byte appears in rx_data with level data_ready 1000 cycles after the start edge; rd_ack clears it.
// No backpressure: a new byte overwrites an unread one and sets sticky overrun.
module uart_rx #(
  parameter int CLKS_PER_BIT = 105,
  parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_ack,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_C = CW'(HALF_BIT);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic          rx_m, rx_s, rx_q;
  logic [1:0]    warm;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg;
  logic          shift_en, store, ferr;

  // cnt counts cycles since the edge-detect cycle, so START is entered with 1.
  // warm masks the reset-forced '1's in the sync chain: a line that is already
  // low when reset lifts must not look like a falling edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_idx;
    shift_en  = 1'b0;
    store     = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (warm == 2'd3 && rx_q && !rx_s) begin
          state_nxt = START;
          cnt_nxt   = CW'(1);
        end
      end
      START: begin
        if (cnt == HALF_C) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST_C) begin
          cnt_nxt  = '0;
          shift_en = 1'b1;
          bit_nxt  = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST_C) begin
          cnt_nxt   = '0;
          store     = rx_s;
          ferr      = !rx_s;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_q       <= 1'b1;
      warm       <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_q      <= rx_s;
      if (warm != 2'd3) warm <= warm + 1'b1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      frame_err <= ferr;
      if (shift_en) shreg <= {rx_s, shreg[7:1]};
      // A store beats a simultaneous rd_ack, which then also means no overrun.
      if (store) begin
        rx_data    <= shreg;
        data_ready <= 1'b1;
        if (data_ready && !rd_ack) overrun <= 1'b1;
      end else if (rd_ack) begin
        data_ready <= 1'b0;
      end
    end
  end

endmodule
